ped_request_scheduler: RTL and testbench

Collects pedestrian crossing requests from NREQ push-buttons, debounces and latches them, and arbitrates among them round-robin. Offers one granted crossing to the traffic-light controller at each phase boundary where a pedestrian phase may be inserted. Sits between the raw board buttons and the traffic-light FSM, replacing its single-button request flag with a multi-crosswalk, fair, handshaked request source.

---
 rtl/sched_pkg.sv | 36 +++
 rtl/btn_debounce.sv | 42 ++++
 rtl/ped_request_scheduler.sv | 124 ++++++++++++
 tb/tb_ped_request_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and helpers for the pedestrian request scheduler.
// Provides the scheduler state encoding and the round-robin picker.
package sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OFFER = 2'd1,
      S_SERVE = 2'd2
   } state_t;

   // Widest request vector the picker handles (NREQ <= 8).
   localparam int MAX_REQ = 8;

   // First set bit of pending at or above rr_ptr, wrapping mod n.
   // Only called when pending is non-zero.
   function automatic logic [2:0] rr_pick(
      input logic [MAX_REQ-1:0] pending,
      input logic [2:0]         rr_ptr,
      input int                 n
   );
      logic [2:0] pick;
      logic       found;
      int         idx;
      pick  = rr_ptr;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % n;
         if (k < n && !found && pending[idx]) begin
            pick  = 3'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchronizer plus stability counter.
// Ports: clk, reset (async, high), btn_n (raw, active-low), pressed (debounced).
module btn_debounce
   import sched_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic pressed
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;

   // Synchronize the inverted level so reset value 0 means released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta    <= 1'b0;
         sync    <= 1'b0;
         cnt     <= '0;
         pressed <= 1'b0;
      end else begin
         meta <= ~btn_n;
         sync <= meta;
         if (sync == pressed) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            pressed <= sync;
            cnt     <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ped_request_scheduler.sv
// Debounces NREQ crosswalk buttons, latches requests and offers them
// round-robin to the light controller with a valid/ack handshake.
// Ports: clk, reset, btn_n[NREQ], slot_open, grant_ack, ped_done ->
//   grant_valid, grant_id, pending[NREQ], busy, timeout_err.
// Optional macro SCHED_TIMEOUT_EN withdraws an unacknowledged offer.
module ped_request_scheduler
   import sched_pkg::*;
#(
   parameter int NREQ            = 4,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int ACK_TIMEOUT     = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         btn_n,
   input  logic                    slot_open,
   input  logic                    grant_ack,
   input  logic                    ped_done,
   output logic                    grant_valid,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic [NREQ-1:0]         pending,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int IW = $clog2(NREQ);

   state_t          state;
   logic [NREQ-1:0] level;
   logic [NREQ-1:0] level_q;
   logic [NREQ-1:0] rise;
   logic [NREQ-1:0] pend;
   logic [NREQ-1:0] clr;
   logic [IW-1:0]   id;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   pick;
   logic [IW-1:0]   next_ptr;
   logic            ack_ok;
   logic            expire;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk    (clk),
         .reset  (reset),
         .btn_n  (btn_n[gi]),
         .pressed(level[gi])
      );
   end

   assign rise     = level & ~level_q;
   assign ack_ok   = (state == S_OFFER) && grant_ack;
   assign pick     = IW'(rr_pick(MAX_REQ'(pend), 3'(rr_ptr), NREQ));
   assign next_ptr = (id == IW'(NREQ - 1)) ? '0 : id + 1'b1;
   // Ack clears after the press is merged, so a same-cycle press is lost.
   assign clr      = ack_ok ? (NREQ'(1) << id) : '0;

`ifdef SCHED_TIMEOUT_EN
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   logic [TW-1:0] to_cnt;
   logic          err;

   // Ack in the expiry cycle takes priority.
   assign expire = (state == S_OFFER) && !grant_ack &&
                   (to_cnt == TW'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
         err    <= 1'b0;
      end else begin
         if (state != S_OFFER) to_cnt <= '0;
         else                  to_cnt <= to_cnt + 1'b1;
         if (expire) err <= 1'b1;
      end
   end

   assign timeout_err = err;
`else
   assign expire      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         id      <= '0;
         rr_ptr  <= '0;
         pend    <= '0;
         level_q <= '0;
      end else begin
         level_q <= level;
         pend    <= (pend | rise) & ~clr;
         case (state)
            S_IDLE: begin
               if (slot_open && |pend) begin
                  id    <= pick;
                  state <= S_OFFER;
               end
            end
            S_OFFER: begin
               if (grant_ack) begin
                  rr_ptr <= next_ptr;
                  state  <= S_SERVE;
               end else if (expire) begin
                  state <= S_IDLE;
               end
            end
            S_SERVE: begin
               if (ped_done) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign grant_valid = (state == S_OFFER);
   assign busy        = (state == S_SERVE);
   assign grant_id    = id;
   assign pending     = pend;

endmodule

// File: tb/tb_ped_request_scheduler.sv
// Self-checking bench for ped_request_scheduler: random presses and
// slots against a queue/array reference model, offers checked by a monitor.
module tb_ped_request_scheduler;

   localparam int NREQ = 4;
   localparam int DB   = 4;
   localparam int TO   = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [NREQ-1:0] btn_n;
   logic            slot_open;
   logic            grant_ack;
   logic            ped_done;
   logic            grant_valid;
   logic [1:0]      grant_id;
   logic [NREQ-1:0] pending;
   logic            busy;
   logic            timeout_err;

   ped_request_scheduler #(
      .NREQ(NREQ), .DEBOUNCE_CYCLES(DB), .ACK_TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset), .btn_n(btn_n),
      .slot_open(slot_open), .grant_ack(grant_ack), .ped_done(ped_done),
      .grant_valid(grant_valid), .grant_id(grant_id), .pending(pending),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: request set and next-search start.
   bit [NREQ-1:0] m_pend;
   int            m_rr;
   int            exp_q[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_pick();
      for (int k = 0; k < NREQ; k++)
         if (m_pend[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
      return -1;
   endfunction

   // Monitor: every rising grant_valid must match the next expected id.
   logic gv_prev = 1'b0;
   int   e;
   always @(negedge clk) begin
      if (reset) begin
         gv_prev = 1'b0;
      end else begin
         if (grant_valid && !gv_prev) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_offer: got id %0d expected none",
                        grant_id);
            end else begin
               e = exp_q.pop_front();
               chk("offer_id", 32'(grant_id), e);
            end
         end
         gv_prev = grant_valid;
      end
   end

   task automatic press(input logic [NREQ-1:0] mask);
      btn_n = ~mask;
      repeat (6) step();
      chk("pend_pre_latency", pending, m_pend);
      step();
      m_pend |= mask;
      chk("pend_latched", pending, m_pend);
      repeat (3) step();
      btn_n = '1;
      repeat (10) step();
   endtask

   task automatic do_slot(input int ack_wait);
      int id;
      id = model_pick();
      slot_open = 1'b1;
      if (id >= 0) exp_q.push_back(id);
      step();
      slot_open = 1'b0;
      chk("offer_valid", grant_valid, (id >= 0));
      if (id < 0) begin
         step();
         chk("idle_no_offer", grant_valid, 0);
         chk("idle_not_busy", busy, 0);
         return;
      end
      repeat (ack_wait) step();
      chk("offer_held", grant_valid, 1);
      grant_ack = 1'b1;
      step();
      grant_ack = 1'b0;
      m_pend[id] = 1'b0;
      m_rr = (id + 1) % NREQ;
      chk("ack_drops_valid", grant_valid, 0);
      chk("ack_busy", busy, 1);
      chk("ack_pend", pending, m_pend);
      repeat ($urandom_range(0, 3)) step();
      ped_done = 1'b1;
      step();
      ped_done = 1'b0;
      chk("done_busy", busy, 0);
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      m_pend = '0;
      m_rr   = 0;
      chk("rst_pending", pending, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", grant_valid, 0);
      chk("rst_id", grant_id, 0);
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int id;
      reset     = 1'b1;
      btn_n     = '1;
      slot_open = 1'b0;
      grant_ack = 1'b0;
      ped_done  = 1'b0;
      m_pend    = '0;
      m_rr      = 0;
      #1;
      chk("reset_valid", grant_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_pending", pending, 0);
      chk("reset_err", timeout_err, 0);
      step();
      step();
      reset = 1'b0;
      step();

      // 3-cycle glitch must not latch.
      btn_n[2] = 1'b0;
      repeat (3) step();
      btn_n = '1;
      repeat (10) step();
      chk("glitch_ignored", pending, 0);

      press(4'b0100);
      do_reset();

      // Round-robin from rr_ptr=0 over 1010.
      press(4'b0010);
      press(4'b1000);
      do_slot(0);
      do_slot(1);
      chk("rr_wrapped", m_rr, 0);
      do_slot(0);

      // Press landing in the ack cycle is lost.
      press(4'b0010);
      btn_n[1] = 1'b0;
      repeat (4) step();
      slot_open = 1'b1;
      exp_q.push_back(model_pick());
      step();
      slot_open = 1'b0;
      chk("coll_offer", grant_valid, 1);
      step();
      grant_ack = 1'b1;
      step();
      grant_ack = 1'b0;
      m_pend[1] = 1'b0;
      m_rr = 2;
      chk("coll_ack_wins", pending, m_pend);
      chk("coll_busy", busy, 1);

      // Press during service latches; slot_open ignored.
      btn_n[0] = 1'b0;
      step();
      slot_open = 1'b1;
      step();
      slot_open = 1'b0;
      repeat (4) step();
      chk("serve_pre", pending, m_pend);
      step();
      m_pend[0] = 1'b1;
      chk("serve_press", pending, m_pend);
      chk("serve_no_offer", grant_valid, 0);
      chk("serve_busy", busy, 1);
      btn_n = '1;
      ped_done = 1'b1;
      step();
      ped_done = 1'b0;
      chk("serve_done", busy, 0);
      repeat (10) step();

      // Randomized phase.
      for (int it = 0; it < 14; it++) begin
         logic [NREQ-1:0] mask;
         mask = NREQ'($urandom_range(0, 15));
         if (mask != '0) press(mask);
         if ($urandom_range(0, 1) == 1) begin
            grant_ack = 1'b1;
            ped_done  = 1'b1;
            step();
            grant_ack = 1'b0;
            ped_done  = 1'b0;
            chk("stray_valid", grant_valid, 0);
            chk("stray_busy", busy, 0);
            chk("stray_pend", pending, m_pend);
         end
         repeat ($urandom_range(1, 3)) do_slot($urandom_range(0, 4));
      end

`ifdef SCHED_TIMEOUT_EN
      press(4'b1000);
      id = model_pick();
      slot_open = 1'b1;
      exp_q.push_back(id);
      step();
      slot_open = 1'b0;
      repeat (TO - 1) step();
      chk("to_still_valid", grant_valid, 1);
      step();
      chk("to_withdrawn", grant_valid, 0);
      chk("to_err", timeout_err, 1);
      chk("to_pend_kept", pending, m_pend);
      do_slot(0);
      chk("to_err_sticky", timeout_err, 1);
`else
      chk("no_timeout_err", timeout_err, 0);
`endif

      // Reset while in service.
      press(4'b0110);
      id = model_pick();
      slot_open = 1'b1;
      exp_q.push_back(id);
      step();
      slot_open = 1'b0;
      grant_ack = 1'b1;
      step();
      grant_ack = 1'b0;
      chk("pre_rst_busy", busy, 1);
      do_reset();
      press(4'b1001);
      do_slot(0);
      chk("post_rst_rr", m_rr, 1);

      step();
      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
